// File: rtl/div_32b_seq_pkg.sv
// Shared divider/multiplier definitions: default widths and sequencer state encodings.
package div_32b_seq_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_32b_seq_if.sv
// Request/response bundle between the control unit (master) and the divider (slave).
interface div_32b_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/div_32b_seq_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor magnitude.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_nxt,
  output logic [WIDTH-1:0] quo_nxt
);
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;

  // rem < divisor_mag, so the shifted value needs one extra bit and the
  // difference one more for its sign.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, divisor_mag};
  assign trial_ok = ~trial[WIDTH+1];

  assign rem_nxt = trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nxt = {quo[WIDTH-2:0], trial_ok};
endmodule

// File: rtl/div_32b_seq.sv
// Multi-cycle restoring divider for div/divu: LO = quotient, HI = remainder.
module div_32b_seq
  import div_32b_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  div_32b_seq_if.slave bus
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dmag;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;
  logic             q_neg, r_neg;
  logic             s_a, s_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign s_a   = bus.is_signed & bus.dividend[WIDTH-1];
  assign s_b   = bus.is_signed & bus.divisor[WIDTH-1];
  assign mag_a = s_a ? -bus.dividend : bus.dividend;
  assign mag_b = s_b ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem),
    .quo         (quo),
    .divisor_mag (dmag),
    .rem_nxt     (rem_nxt),
    .quo_nxt     (quo_nxt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      IDLE:    if (bus.start && bus.divisor != '0) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt             <= '0;
      rem             <= '0;
      quo             <= '0;
      dmag            <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide-by-zero completes immediately without occupying the datapath.
            bus.quotient    <= '1;
            bus.remainder   <= bus.dividend;
            bus.div_by_zero <= 1'b1;
            bus.done        <= 1'b1;
          end else begin
            rem      <= '0;
            quo      <= mag_a;
            dmag     <= mag_b;
            q_neg    <= s_a ^ s_b;
            r_neg    <= s_a;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RUN: begin
          rem <= rem_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          bus.quotient    <= q_neg ? -quo : quo;
          bus.remainder   <= r_neg ? -rem : rem;
          bus.div_by_zero <= 1'b0;
          bus.done        <= 1'b1;
          bus.busy        <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_32b_seq.sv
// Directed checks for div_32b_seq: signed/unsigned results, timing, div-by-zero, reset abort.
module tb_div_32b_seq;
  logic clk = 1'b0;
  logic reset_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  div_32b_seq_if #(.WIDTH(32)) dif ();

  div_32b_seq dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (dif.slave)
  );

  // Drives one request from the current negedge and waits (bounded) for done.
  // edges = negedges after the start edge until done is seen (0 = right after it).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int edges, output int busy_n, output logic overlap,
                        output logic [31:0] q, output logic [31:0] r, output logic dz);
    dif.start = 1'b1; dif.is_signed = s; dif.dividend = a; dif.divisor = b;
    @(negedge clk);
    dif.start = 1'b0; dif.is_signed = ~s; dif.dividend = $urandom; dif.divisor = $urandom;
    edges = 0; busy_n = 0; overlap = 1'b0;
    while (!dif.done && edges < 100) begin
      if (dif.busy) busy_n++;
      @(negedge clk);
      edges++;
    end
    overlap = dif.busy && dif.done;
    q = dif.quotient; r = dif.remainder; dz = dif.div_by_zero;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    dif.start = 1'b0; dif.is_signed = 1'b0; dif.dividend = '0; dif.divisor = '0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero} !== 67'd0)
      $display("FAIL reset_state q=%h r=%h busy=%b done=%b dz=%b want all 0",
               dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero);
    else pass_cnt++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_divu_basic();
    int e, bn; logic ov, dz; logic [31:0] q, r;
    run_op(32'd100, 32'd7, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if (e !== 33) $display("FAIL divu_latency got=%0d want=33", e); else pass_cnt++;
    total_cnt++;
    if (bn !== 33) $display("FAIL divu_busy_cycles got=%0d want=33", bn); else pass_cnt++;
    total_cnt++;
    if (ov !== 1'b0) $display("FAIL divu_busy_done_overlap got=%b want=0", ov); else pass_cnt++;
    total_cnt++;
    if ({q, r, dz} !== {32'd14, 32'd2, 1'b0})
      $display("FAIL divu_100_7 q=%h r=%h dz=%b want q=0000000e r=00000002 dz=0", q, r, dz);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (dif.done !== 1'b0) $display("FAIL done_pulse_width done=%b want=0", dif.done);
    else pass_cnt++;
    total_cnt++;
    if ({dif.quotient, dif.remainder} !== {32'd14, 32'd2})
      $display("FAIL result_hold q=%h r=%h want 0000000e/00000002", dif.quotient, dif.remainder);
    else pass_cnt++;
  endtask

  task automatic test_signed();
    int e, bn; logic ov, dz; logic [31:0] q, r;
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF})
      $display("FAIL div_m7_2 q=%h r=%h want fffffffd/ffffffff", q, r);
    else pass_cnt++;
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r} !== {32'hFFFF_FFFD, 32'd1})
      $display("FAIL div_7_m2 q=%h r=%h want fffffffd/00000001", q, r);
    else pass_cnt++;
    run_op(32'hFFFF_FFFF, 32'h10, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r} !== {32'h0FFF_FFFF, 32'hF})
      $display("FAIL divu_max_16 q=%h r=%h want 0fffffff/0000000f", q, r);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    int e, bn; logic ov, dz; logic [31:0] q, r;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r} !== {32'h8000_0000, 32'd0})
      $display("FAIL div_overflow q=%h r=%h want 80000000/00000000", q, r);
    else pass_cnt++;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r} !== {32'd0, 32'h8000_0000})
      $display("FAIL divu_big q=%h r=%h want 00000000/80000000", q, r);
    else pass_cnt++;
  endtask

  // Second op is started on the same negedge that done of the first is seen.
  task automatic test_div_zero();
    int e, bn; logic ov, dz; logic [31:0] q, r;
    run_op(32'd5, 32'd0, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if (e !== 0) $display("FAIL dz_latency got=%0d want=0", e); else pass_cnt++;
    total_cnt++;
    if (bn !== 0 || dif.busy !== 1'b0) $display("FAIL dz_busy got=%0d/%b want=0", bn, dif.busy);
    else pass_cnt++;
    total_cnt++;
    if ({q, r, dz} !== {32'hFFFF_FFFF, 32'd5, 1'b1})
      $display("FAIL divu_5_0 q=%h r=%h dz=%b want ffffffff/00000005/1", q, r, dz);
    else pass_cnt++;
    run_op(32'hFFFF_FFFF, 32'd1, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if (e !== 33) $display("FAIL back_to_back_latency got=%0d want=33", e); else pass_cnt++;
    total_cnt++;
    if ({q, r, dz} !== {32'hFFFF_FFFF, 32'd0, 1'b0})
      $display("FAIL divu_max_1 q=%h r=%h dz=%b want ffffffff/00000000/0", q, r, dz);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int e;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (5) @(negedge clk);
    dif.start = 1'b1; dif.dividend = 32'd50; dif.divisor = 32'd5;
    @(negedge clk);
    dif.start = 1'b0;
    e = 6;
    while (!dif.done && e < 100) begin @(negedge clk); e++; end
    total_cnt++;
    if (e !== 33) $display("FAIL ignored_start_latency got=%0d want=33", e); else pass_cnt++;
    total_cnt++;
    if ({dif.quotient, dif.remainder} !== {32'd14, 32'd2})
      $display("FAIL ignored_start q=%h r=%h want 0000000e/00000002", dif.quotient, dif.remainder);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int e, bn, done_seen; logic ov, dz; logic [31:0] q, r;
    dif.start = 1'b1; dif.is_signed = 1'b0; dif.dividend = 32'd100; dif.divisor = 32'd7;
    @(negedge clk);
    dif.start = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    total_cnt++;
    if ({dif.quotient, dif.remainder, dif.busy, dif.done, dif.div_by_zero} !== 67'd0)
      $display("FAIL reset_midop q=%h r=%h busy=%b done=%b want all 0",
               dif.quotient, dif.remainder, dif.busy, dif.done);
    else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin @(negedge clk); if (dif.done || dif.busy) done_seen++; end
    total_cnt++;
    if (done_seen !== 0) $display("FAIL reset_no_done activity=%0d want=0", done_seen);
    else pass_cnt++;
    run_op(32'd7, 32'd16, 1'b0, e, bn, ov, q, r, dz);
    total_cnt++;
    if ({q, r, e} !== {32'd0, 32'd7, 32'd33})
      $display("FAIL divu_7_16 q=%h r=%h lat=%0d want 00000000/00000007/33", q, r, e);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_start_ignored();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
